enet_rx_fifo_ctrl: RTL and testbench

RX FIFO occupancy controller for the ENET receive path, in the `rx_clk` domain alongside the RX configuration registers. It tracks words written by the MAC receive engine and words drained by the RX DMA, and commits or discards frames. It applies the section-full (RSFL), section-empty (RSEM) and almost-full/empty (RAFL/RAEM) thresholds to produce the DMA request, XOFF pause request and FIFO status flags. The FIFO RAM and its pointers live outside this block; this block drives their write-accept and rewind controls.

---
 rtl/enet_rx_fifo_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_enet_rx_fifo_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enet_rx_fifo_ctrl.sv
// enet_rx_fifo_ctrl
// Occupancy controller for the ENET RX FIFO. It counts the words of the
// frame being received (pending) separately from the words of complete frames
// (committed). An overrun frame is rewound out of the RAM, and the block
// derives the DMA request, XOFF request and FIFO status flags from the
// programmable thresholds.
module enet_rx_fifo_ctrl #(
  parameter int DEPTH = 128
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic [7:0] rsfl,
  input  logic [7:0] rsem_rx,
  input  logic [7:0] rafl,
  input  logic [7:0] raem,
  input  logic       wr_en,
  input  logic       wr_sof,
  input  logic       wr_eof,
  output logic       wr_accept,
  output logic       wr_rewind,
  input  logic       rd_en,
  input  logic       rd_eof,
  output logic [7:0] level,
  output logic [7:0] frames,
  output logic       empty,
  output logic       full,
  output logic       almost_full,
  output logic       almost_empty,
  output logic       dma_req,
  output logic       xoff_req,
  output logic       ovf_pulse,
  output logic       udf_pulse
);

  // Depth widened by one bit so that the value 128 can be compared against 8-bit counts.
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  wr_state_e  state_r;
  wr_state_e  state_next_s;
  logic [7:0] pending_r;
  logic [7:0] committed_r;
  logic [7:0] level_r;
  logic [7:0] frames_r;
  logic       empty_r;
  logic       full_r;
  logic       almost_full_r;
  logic       almost_empty_r;
  logic       dma_req_r;
  logic       xoff_req_r;
  logic       wr_rewind_r;
  logic       ovf_r;
  logic       udf_r;

  logic [7:0] pending_next_s;
  logic [7:0] committed_next_s;
  logic [7:0] level_next_s;
  logic [7:0] frames_next_s;
  logic [8:0] frames_sum_s;
  logic [7:0] commit_words_s;
  logic       commit_s;
  logic       rewind_s;
  logic       ovf_s;
  logic       rd_ok_s;
  logic       rd_eof_ok_s;
  logic       udf_s;

  assign level        = level_r;
  assign frames       = frames_r;
  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign dma_req      = dma_req_r;
  assign xoff_req     = xoff_req_r;
  assign wr_rewind    = wr_rewind_r;
  assign ovf_pulse    = ovf_r;
  assign udf_pulse    = udf_r;

  // The RAM write enable: a word is stored only inside a frame that is being received, and only when there is room.
  always_comb begin
    wr_accept = wr_en & ~full_r &
                ((state_r == ST_RECV) | ((state_r == ST_IDLE) & wr_sof));
  end

  // Write-side decode: frame start, continue, commit, overrun rewind and drop.
  always_comb begin
    state_next_s   = state_r;
    pending_next_s = pending_r;
    commit_s       = 1'b0;
    commit_words_s = 8'd0;
    rewind_s       = 1'b0;
    ovf_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wr_en && wr_sof) begin
          if (full_r) begin
            ovf_s        = 1'b1;
            state_next_s = wr_eof ? ST_IDLE : ST_DROP;
          end else if (wr_eof) begin
            commit_s       = 1'b1;
            commit_words_s = 8'd1;
            pending_next_s = 8'd0;
          end else begin
            pending_next_s = 8'd1;
            state_next_s   = ST_RECV;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (wr_en) begin
          if (full_r) begin
            // Overrun: the partial frame is rewound out of the RAM and the rest of it is dropped.
            rewind_s       = 1'b1;
            ovf_s          = 1'b1;
            pending_next_s = 8'd0;
            state_next_s   = wr_eof ? ST_IDLE : ST_DROP;
          end else if (wr_sof) begin
            // End of frame went missing: rewind the old frame and take this word as a new first word.
            rewind_s = 1'b1;
            ovf_s    = 1'b1;
            if (wr_eof) begin
              commit_s       = 1'b1;
              commit_words_s = 8'd1;
              pending_next_s = 8'd0;
              state_next_s   = ST_IDLE;
            end else begin
              pending_next_s = 8'd1;
              state_next_s   = ST_RECV;
            end
          end else if (wr_eof) begin
            commit_s       = 1'b1;
            commit_words_s = pending_r + 8'd1;
            pending_next_s = 8'd0;
            state_next_s   = ST_IDLE;
          end else begin
            pending_next_s = pending_r + 8'd1;
          end
        end else begin
          state_next_s = ST_RECV;
        end
      end
      ST_DROP: begin
        if (wr_en && wr_eof) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DROP;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        pending_next_s = 8'd0;
      end
    endcase
  end

  // Read-side decode: only committed words and complete frames can be drained.
  always_comb begin
    rd_ok_s     = rd_en & (committed_r != 8'd0);
    rd_eof_ok_s = rd_en & rd_eof & (frames_r != 8'd0);
    udf_s       = (rd_en & (committed_r == 8'd0)) | (rd_en & rd_eof & (frames_r == 8'd0));
  end

  // Next-state counters; frames saturates at 255 rather than wrapping.
  always_comb begin
    committed_next_s = committed_r - {7'd0, rd_ok_s} + commit_words_s;
    level_next_s     = committed_next_s + pending_next_s;
    frames_sum_s     = {1'b0, frames_r} + {8'd0, commit_s} - {8'd0, rd_eof_ok_s};
    if (frames_sum_s[8]) begin
      frames_next_s = 8'hFF;
    end else begin
      frames_next_s = frames_sum_s[7:0];
    end
  end

  // Register the write state, the counters and every flag, all derived from next-state values.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      pending_r      <= 8'd0;
      committed_r    <= 8'd0;
      level_r        <= 8'd0;
      frames_r       <= 8'd0;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      dma_req_r      <= 1'b0;
      xoff_req_r     <= 1'b0;
      wr_rewind_r    <= 1'b0;
      ovf_r          <= 1'b0;
      udf_r          <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      pending_r      <= pending_next_s;
      committed_r    <= committed_next_s;
      level_r        <= level_next_s;
      frames_r       <= frames_next_s;
      empty_r        <= (level_next_s == 8'd0);
      full_r         <= ({1'b0, level_next_s} == DEPTH_W);
      almost_full_r  <= ((DEPTH_W - {1'b0, level_next_s}) <= {1'b0, rafl});
      almost_empty_r <= (level_next_s <= raem);
      dma_req_r      <= (frames_next_s != 8'd0) |
                        ((rsfl != 8'd0) & (committed_next_s >= rsfl));
      xoff_req_r     <= (rsem_rx != 8'd0) & (level_next_s >= rsem_rx);
      wr_rewind_r    <= rewind_s;
      ovf_r          <= ovf_s;
      udf_r          <= udf_s;
    end
  end

endmodule

// File: tb/tb_enet_rx_fifo_ctrl.sv
// tb_enet_rx_fifo_ctrl
// Scoreboard bench. The driver applies one cycle of stimulus at each falling
// edge and updates a frame-level model of the FIFO contents. It then queues
// the expected outputs. Two monitor processes pop those expectations and
// compare them: wr_accept shortly after the drive, and the registered
// outputs just after the rising edge.
module tb_enet_rx_fifo_ctrl;

  localparam int DEPTH = 128;

  logic       rx_clk = 1'b0;
  logic       rst;
  logic [7:0] rsfl, rsem_rx, rafl, raem;
  logic       wr_en, wr_sof, wr_eof, rd_en, rd_eof;
  logic       wr_accept, wr_rewind;
  logic [7:0] level, frames;
  logic       empty, full, almost_full, almost_empty;
  logic       dma_req, xoff_req, ovf_pulse, udf_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Thresholds requested by the stimulus; they reach the DUT pins at the next drive.
  int t_rsfl = 0, t_rsem = 0, t_rafl = 0, t_raem = 0;

  // Reference model: word counts of stored frames and of the frame in flight.
  int m_committed = 0;
  int m_frames    = 0;
  int m_cur       = 0;
  bit m_in_frame  = 1'b0;
  bit m_dropping  = 1'b0;

  typedef struct {
    int level;
    int frames;
    bit empty, full, af, ae, dma, xoff, rew, ovf, udf;
  } exp_t;

  exp_t exp_q[$];
  bit   acc_q[$];

  always #5 rx_clk = ~rx_clk;

  enet_rx_fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .rx_clk(rx_clk), .rst(rst),
    .rsfl(rsfl), .rsem_rx(rsem_rx), .rafl(rafl), .raem(raem),
    .wr_en(wr_en), .wr_sof(wr_sof), .wr_eof(wr_eof),
    .wr_accept(wr_accept), .wr_rewind(wr_rewind),
    .rd_en(rd_en), .rd_eof(rd_eof),
    .level(level), .frames(frames),
    .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .dma_req(dma_req), .xoff_req(xoff_req),
    .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  function automatic bit pct(input int p);
    return ($urandom_range(0, 99) < p);
  endfunction

  // One clock of stimulus plus the model's view of what that edge must produce.
  task automatic step(input bit r, input bit we, input bit sof, input bit eof,
                      input bit re, input bit reof);
    exp_t e;
    bit   acc, rew, ovf, udf, full_now, start, commit;
    int   rd_ok, rdeof_ok, lvl;
    @(negedge rx_clk);
    rst = r; wr_en = we; wr_sof = sof; wr_eof = eof; rd_en = re; rd_eof = reof;
    rsfl = 8'(t_rsfl); rsem_rx = 8'(t_rsem); rafl = 8'(t_rafl); raem = 8'(t_raem);
    acc = 1'b0; rew = 1'b0; ovf = 1'b0; udf = 1'b0; start = 1'b0; commit = 1'b0;
    if (r) begin
      m_committed = 0; m_frames = 0; m_cur = 0; m_in_frame = 1'b0; m_dropping = 1'b0;
      e = '{level: 0, frames: 0, empty: 1'b1, full: 1'b0, af: 1'b0, ae: 1'b1,
            dma: 1'b0, xoff: 1'b0, rew: 1'b0, ovf: 1'b0, udf: 1'b0};
    end else begin
      full_now = (m_committed + m_cur) == DEPTH;
      rd_ok    = (re && m_committed > 0) ? 1 : 0;
      rdeof_ok = (re && reof && m_frames > 0) ? 1 : 0;
      udf      = (re && m_committed == 0) || (re && reof && m_frames == 0);
      if (we) begin
        if (m_dropping) begin
          if (eof) m_dropping = 1'b0;
        end else if (m_in_frame) begin
          if (full_now || sof) begin
            rew = 1'b1; ovf = 1'b1; m_cur = 0; m_in_frame = 1'b0;
            if (full_now) m_dropping = !eof;
            else start = 1'b1;
          end else begin
            acc = 1'b1; m_cur++;
            if (eof) begin commit = 1'b1; m_in_frame = 1'b0; end
          end
        end else if (sof) begin
          start = 1'b1;
        end
        if (start) begin
          if (full_now) begin
            ovf = 1'b1; m_dropping = !eof;
          end else begin
            acc = 1'b1; m_cur = 1; m_in_frame = 1'b1;
            if (eof) begin commit = 1'b1; m_in_frame = 1'b0; end
          end
        end
      end
      m_committed = m_committed - rd_ok;
      if (commit) begin m_committed += m_cur; m_cur = 0; end
      m_frames = m_frames + (commit ? 1 : 0) - rdeof_ok;
      if (m_frames > 255) m_frames = 255;
      lvl = m_committed + m_cur;
      e.level  = lvl;
      e.frames = m_frames;
      e.empty  = (lvl == 0);
      e.full   = (lvl == DEPTH);
      e.af     = (DEPTH - lvl) <= t_rafl;
      e.ae     = lvl <= t_raem;
      e.dma    = (m_frames != 0) || (t_rsfl != 0 && m_committed >= t_rsfl);
      e.xoff   = (t_rsem != 0) && (lvl >= t_rsem);
      e.rew    = rew;
      e.ovf    = ovf;
      e.udf    = udf;
    end
    acc_q.push_back(acc);
    exp_q.push_back(e);
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, i == 0, i == n - 1, 1'b0, 1'b0);
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, i == n - 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_phase(input int ncyc, input int p_wr, input int p_sof, input int p_eof,
                            input int p_rd, input int p_rdeof);
    t_rsfl = $urandom_range(0, 130);
    t_rsem = $urandom_range(0, 128);
    t_rafl = $urandom_range(0, 20);
    t_raem = $urandom_range(0, 20);
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(0, 999) == 0) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else step(1'b0, pct(p_wr), pct(p_sof), pct(p_eof), pct(p_rd), pct(p_rdeof));
    end
  endtask

  // Monitor for the combinational write-accept, sampled after each drive settles.
  initial begin
    bit a;
    forever begin
      @(negedge rx_clk);
      #2;
      if (acc_q.size() > 0) begin
        a = acc_q.pop_front();
        chk("wr_accept", wr_accept, a);
      end
    end
  end

  // Monitor for the registered outputs, sampled just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge rx_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("level", level, e.level);
        chk("frames", frames, e.frames);
        chk("empty", empty, e.empty);
        chk("full", full, e.full);
        chk("almost_full", almost_full, e.af);
        chk("almost_empty", almost_empty, e.ae);
        chk("dma_req", dma_req, e.dma);
        chk("xoff_req", xoff_req, e.xoff);
        chk("wr_rewind", wr_rewind, e.rew);
        chk("ovf_pulse", ovf_pulse, e.ovf);
        chk("udf_pulse", udf_pulse, e.udf);
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic phases.
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0; rd_en = 1'b0; rd_eof = 1'b0;
    rsfl = 8'd0; rsem_rx = 8'd0; rafl = 8'd0; raem = 8'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Store-and-forward: 4-word frame, dma_req only after the last word.
    frame(4);
    idle(1);
    pop(4);

    // Section-full threshold: pending words do not count toward dma_req.
    t_rsfl = 3;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, i == 0, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pop(11);
    t_rsfl = 0;

    // Commit 8 words, then drain them with rd_eof on the last word.
    frame(8);
    pop(8);

    // Fill up to the XOFF and almost-full boundaries, then overrun.
    t_rafl = 4; t_raem = 4; t_rsem = 100;
    frame(100);
    frame(23);
    frame(1);
    frame(1);
    frame(5);
    idle(1);
    pop(125);

    // Underflow while empty, then simultaneous write and read at level 50.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(50);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Missing end of frame: a new sof rewinds the old frame.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Randomized traffic: write-heavy, balanced, read-heavy, short frames.
    rand_phase(1500, 90, 8, 8, 10, 20);
    rand_phase(1500, 60, 15, 15, 55, 30);
    rand_phase(1500, 30, 20, 20, 80, 50);
    rand_phase(1500, 85, 50, 50, 30, 5);

    idle(2);
    @(negedge rx_clk);
    @(negedge rx_clk);
    chk("scoreboard_drained", exp_q.size() + acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
